// File: rtl/count_ctrl_conditioner.sv
// Input conditioning ahead of the 4-bit up/down counter: synchronizes and debounces
// the test/ud/en pads and derives the registered cnt_tick advance strobe.
module count_ctrl_conditioner #(
   parameter int DB_CYCLES = 8,
   parameter int PRE_WIDTH = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic test_raw,
   input  logic ud_raw,
   input  logic en_raw,
   output logic test_q,
   output logic ud_q,
   output logic en_q,
   output logic cnt_tick
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   // Bit order in the per-input vectors: [0] test, [1] ud, [2] en.
   logic [2:0]           raw;
   logic [2:0]           s1;
   logic [2:0]           s2;
   logic [2:0]           q;
   logic [CW-1:0]        c [3];
   logic [PRE_WIDTH-1:0] pre;
   logic                 ud_d;
   logic                 dir_chg;

   assign raw = {en_raw, ud_raw, test_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         q  <= '0;
         for (int i = 0; i < 3; i++) c[i] <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         // The counter restarts whenever the synchronized level falls back to q.
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == q[i]) begin
               c[i] <= '0;
            end else if (c[i] == CW'(DB_CYCLES - 1)) begin
               q[i] <= s2[i];
               c[i] <= '0;
            end else begin
               c[i] <= c[i] + CW'(1);
            end
         end
      end
   end

   assign test_q = q[0];
   assign ud_q   = q[1];
   assign en_q   = q[2];

   always_ff @(posedge clk) begin
      if (rst || !en_q) pre <= '0;
      else              pre <= pre + PRE_WIDTH'(1);
   end

   // Suppress the advance in the cycle the new direction first appears.
   assign dir_chg = ud_q ^ ud_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         ud_d     <= 1'b0;
         cnt_tick <= 1'b0;
      end else begin
         ud_d     <= ud_q;
         cnt_tick <= en_q & ~dir_chg & (test_q | (&pre));
      end
   end

endmodule

// File: tb/tb_count_ctrl_conditioner.sv
// Directed bench for count_ctrl_conditioner with DB_CYCLES=4, PRE_WIDTH=3.
module tb_count_ctrl_conditioner;

   localparam int DB = 4;
   localparam int PW = 3;

   logic clk = 1'b0;
   logic rst;
   logic test_raw;
   logic ud_raw;
   logic en_raw;
   logic test_q;
   logic ud_q;
   logic en_q;
   logic cnt_tick;

   int n_chk  = 0;
   int n_fail = 0;

   count_ctrl_conditioner #(.DB_CYCLES(DB), .PRE_WIDTH(PW)) dut (
      .clk      (clk),
      .rst      (rst),
      .test_raw (test_raw),
      .ud_raw   (ud_raw),
      .en_raw   (en_raw),
      .test_q   (test_q),
      .ud_q     (ud_q),
      .en_q     (en_q),
      .cnt_tick (cnt_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic t, input logic u, input logic e, input logic k);
      chk({tag, "_test_q"}, 32'(test_q), 32'(t));
      chk({tag, "_ud_q"}, 32'(ud_q), 32'(u));
      chk({tag, "_en_q"}, 32'(en_q), 32'(e));
      chk({tag, "_tick"}, 32'(cnt_tick), 32'(k));
   endtask

   initial begin
      logic exp_tick;

      // Reset held with all raw inputs high: everything stays low.
      rst = 1'b1; test_raw = 1'b1; ud_raw = 1'b1; en_raw = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("post_reset_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step();
      chk_all("q_rise_6th_edge", 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      chk("first_dir_chg_tick", 32'(cnt_tick), 32'd0);
      for (int i = 1; i <= 2; i++) begin
         step();
         chk("fast_tick", 32'(cnt_tick), 32'd1);
      end

      // Direction flip in fast mode: single suppressed tick one cycle after ud_q changes.
      ud_raw = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("dir_ud_q", 32'(ud_q), 32'(k < 6));
         chk("dir_tick", 32'(cnt_tick), 32'(k != 7));
         chk("dir_en_q", 32'(en_q), 32'd1);
      end

      // Reset while outputs are high clears all state.
      rst = 1'b1; test_raw = 1'b0; ud_raw = 1'b0; en_raw = 1'b0;
      step();
      chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         step();
         chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Bounce rejection: 3 high / 1 low, five times.
      for (int r = 0; r < 5; r++) begin
         en_raw = 1'b1;
         for (int i = 1; i <= 3; i++) begin
            step();
            chk("bounce_en_q", 32'(en_q), 32'd0);
         end
         en_raw = 1'b0;
         step();
         chk("bounce_en_q", 32'(en_q), 32'd0);
      end
      en_raw = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("hold_en_q", 32'(en_q), 32'(k == 6));
         chk("hold_tick", 32'(cnt_tick), 32'd0);
      end

      // From en_q rise (k=0): prescaler, fast-mode window, enable drop and re-enable.
      for (int k = 1; k <= 81; k++) begin
         step();
         exp_tick = (k <= 24 && (k % 8) == 0) ||
                    (k >= 25 && k <= 48 && ((k >= 31 && k <= 37) || (k % 8) == 0)) ||
                    k == 72 || k == 80;
         chk("run_tick", 32'(cnt_tick), 32'(exp_tick));
         chk("run_test_q", 32'(test_q), 32'(k >= 30 && k <= 36));
         chk("run_en_q", 32'(en_q), 32'(k <= 53 || k >= 64));
         chk("run_ud_q", 32'(ud_q), 32'd0);
         if (k == 54) chk("pre_at_en_fall", 32'(dut.pre), 32'd6);
         if (k == 55) chk("pre_after_en_fall", 32'(dut.pre), 32'd0);
         if (k == 64) chk("pre_at_en_rise", 32'(dut.pre), 32'd0);
         if (k == 24) test_raw = 1'b1;
         if (k == 31) test_raw = 1'b0;
         if (k == 48) en_raw = 1'b0;
         if (k == 58) en_raw = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
